// File: rtl/rv_sdram_bridge_if.sv
// Bus bundles for the softcore-to-sdram_snes RISC-V bridge: the 32-bit softcore memory port
// and the 16-bit rv_* request port.
interface mem_bus_if;
  logic        mem_valid;
  logic [22:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  input  mem_ready, mem_rdata);
  modport slave  (input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  output mem_ready, mem_rdata);
endinterface

interface rv_bus_if;
  logic [21:0] rv_addr;
  logic [15:0] rv_din;
  logic [1:0]  rv_ds;
  logic        rv_rd;
  logic        rv_wr;
  logic        rv_wait;
  logic [15:0] rv_dout;

  modport master (output rv_addr, rv_din, rv_ds, rv_rd, rv_wr,
                  input  rv_wait, rv_dout);
  modport slave  (input  rv_addr, rv_din, rv_ds, rv_rd, rv_wr,
                  output rv_wait, rv_dout);
endinterface

// File: rtl/rv_sdram_bridge.sv
// Splits one 32-bit softcore access into low/high 16-bit rv_* accesses, retrying while rv_wait
// is high, and reassembles read halves into mem_rdata with a single mem_ready pulse.
module rv_sdram_bridge #(
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned WAIT_MAX   = 255
) (
  input  logic       clk,
  input  logic       resetn,
  mem_bus_if.slave   mem,
  rv_bus_if.master   rv,
  output logic       err_timeout
);

  typedef enum logic [2:0] {IDLE, REQ_LO, RD_LO, REQ_HI, RD_HI, DONE} state_t;

  localparam logic [2:0] LAT  = RD_LATENCY[2:0];
  localparam logic [8:0] WMAX = WAIT_MAX[8:0];

  state_t      state_q, state_d;
  logic [20:0] base_q, base_d;
  logic [15:0] hi_din_q, hi_din_d;
  logic [1:0]  hi_ds_q, hi_ds_d;
  logic        is_rd_q, is_rd_d;
  logic [2:0]  lat_q, lat_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] rd_lo_q, rd_lo_d;
  logic [21:0] rv_addr_q, rv_addr_d;
  logic [15:0] rv_din_q, rv_din_d;
  logic [1:0]  rv_ds_q, rv_ds_d;
  logic        rv_rd_q, rv_rd_d;
  logic        rv_wr_q, rv_wr_d;
  logic        mem_ready_q, mem_ready_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        err_q, err_d;

  logic        new_rd;
  logic        accept;
  logic [8:0]  wait_inc;
  logic        unused_addr_lsb;

  assign new_rd          = (mem.mem_wstrb == 4'b0000);
  assign accept          = (rv_rd_q | rv_wr_q) & ~rv.rv_wait;
  assign wait_inc        = {1'b0, wait_q} + 9'd1;
  assign unused_addr_lsb = ^mem.mem_addr[1:0];

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    hi_din_d    = hi_din_q;
    hi_ds_d     = hi_ds_q;
    is_rd_d     = is_rd_q;
    lat_d       = lat_q;
    wait_d      = wait_q;
    rd_lo_d     = rd_lo_q;
    rv_addr_d   = rv_addr_q;
    rv_din_d    = rv_din_q;
    rv_ds_d     = rv_ds_q;
    rv_rd_d     = rv_rd_q;
    rv_wr_d     = rv_wr_q;
    mem_ready_d = 1'b0;
    mem_rdata_d = mem_rdata_q;
    err_d       = err_q;

    // Wait accounting is shared by both request states; the counter saturates at 8 bits.
    if ((state_q == REQ_LO || state_q == REQ_HI) && rv.rv_wait) begin
      if (wait_q != 8'hFF) wait_d = wait_inc[7:0];
      if (wait_inc >= WMAX) err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (mem.mem_valid) begin
          base_d   = mem.mem_addr[22:2];
          hi_din_d = mem.mem_wdata[31:16];
          is_rd_d  = new_rd;
          if (new_rd) begin
            hi_ds_d   = 2'b11;
            state_d   = REQ_LO;
            rv_rd_d   = 1'b1;
            rv_addr_d = {mem.mem_addr[22:2], 1'b0};
            rv_din_d  = 16'h0000;
            rv_ds_d   = 2'b11;
          end else begin
            hi_ds_d = mem.mem_wstrb[3:2];
            rv_wr_d = 1'b1;
            // A write with no low strobes goes straight to the high half.
            if (mem.mem_wstrb[1:0] != 2'b00) begin
              state_d   = REQ_LO;
              rv_addr_d = {mem.mem_addr[22:2], 1'b0};
              rv_din_d  = mem.mem_wdata[15:0];
              rv_ds_d   = mem.mem_wstrb[1:0];
            end else begin
              state_d   = REQ_HI;
              rv_addr_d = {mem.mem_addr[22:2], 1'b1};
              rv_din_d  = mem.mem_wdata[31:16];
              rv_ds_d   = mem.mem_wstrb[3:2];
            end
          end
        end
      end
      REQ_LO: begin
        if (accept) begin
          wait_d = 8'h00;
          if (is_rd_q) begin
            rv_rd_d = 1'b0;
            lat_d   = 3'd1;
            state_d = RD_LO;
          end else if (hi_ds_q != 2'b00) begin
            state_d   = REQ_HI;
            rv_addr_d = {base_q, 1'b1};
            rv_din_d  = hi_din_q;
            rv_ds_d   = hi_ds_q;
          end else begin
            rv_wr_d     = 1'b0;
            state_d     = DONE;
            mem_ready_d = 1'b1;
          end
        end
      end
      RD_LO: begin
        if (lat_q == LAT) begin
          rd_lo_d   = rv.rv_dout;
          state_d   = REQ_HI;
          rv_rd_d   = 1'b1;
          rv_addr_d = {base_q, 1'b1};
          rv_ds_d   = 2'b11;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      REQ_HI: begin
        if (accept) begin
          wait_d = 8'h00;
          if (is_rd_q) begin
            rv_rd_d = 1'b0;
            lat_d   = 3'd1;
            state_d = RD_HI;
          end else begin
            rv_wr_d     = 1'b0;
            state_d     = DONE;
            mem_ready_d = 1'b1;
          end
        end
      end
      RD_HI: begin
        if (lat_q == LAT) begin
          mem_rdata_d = {rv.rv_dout, rd_lo_q};
          state_d     = DONE;
          mem_ready_d = 1'b1;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      base_q      <= '0;
      hi_din_q    <= '0;
      hi_ds_q     <= '0;
      is_rd_q     <= 1'b0;
      lat_q       <= '0;
      wait_q      <= '0;
      rd_lo_q     <= '0;
      rv_addr_q   <= '0;
      rv_din_q    <= '0;
      rv_ds_q     <= '0;
      rv_rd_q     <= 1'b0;
      rv_wr_q     <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      hi_din_q    <= hi_din_d;
      hi_ds_q     <= hi_ds_d;
      is_rd_q     <= is_rd_d;
      lat_q       <= lat_d;
      wait_q      <= wait_d;
      rd_lo_q     <= rd_lo_d;
      rv_addr_q   <= rv_addr_d;
      rv_din_q    <= rv_din_d;
      rv_ds_q     <= rv_ds_d;
      rv_rd_q     <= rv_rd_d;
      rv_wr_q     <= rv_wr_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem.mem_ready = mem_ready_q;
  assign mem.mem_rdata = mem_rdata_q;
  assign rv.rv_addr    = rv_addr_q;
  assign rv.rv_din     = rv_din_q;
  assign rv.rv_ds      = rv_ds_q;
  assign rv.rv_rd      = rv_rd_q;
  assign rv.rv_wr      = rv_wr_q;
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_rv_sdram_bridge.sv
// Scoreboard bench for rv_sdram_bridge: a word-level reference memory predicts rv_* halves and
// mem_rdata; a half-word sdram responder and independent monitors check the DUT.
module tb_rv_sdram_bridge;
  localparam int L    = 2;
  localparam int WMAX = 255;

  typedef struct {
    bit          is_rd;
    logic [21:0] addr;
    logic [15:0] din;
    logic [1:0]  ds;
  } rv_exp_t;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    int          lat;
    int          issue;
  } rsp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic err_timeout;

  mem_bus_if mem();
  rv_bus_if  rv();

  rv_sdram_bridge #(.RD_LATENCY(L), .WAIT_MAX(WMAX)) dut (
    .clk(clk), .resetn(resetn), .mem(mem), .rv(rv), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] ref_mem [1024];
  logic [15:0] sd_mem  [2048];
  rv_exp_t     rv_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] last_rdata = 32'h0;
  bit          exp_err = 1'b0;
  int          half_waits = 0;
  int          wait_pending = 0;
  bit          wait_rand = 1'b0;
  int          rd_due = -1;
  logic [15:0] rd_data = 16'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] seed_half(input int h);
    return 16'((h * 32'h1357) ^ 32'h5AC3);
  endfunction

  // sdram_snes stand-in: wait generation and read data valid exactly RD_LATENCY edges after accept
  initial begin
    rv.rv_wait = 1'b0;
    rv.rv_dout = 16'h0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (wait_pending > 0)  rv.rv_wait = 1'b1;
      else if (wait_rand)    rv.rv_wait = ($urandom_range(0, 3) == 0);
      else                   rv.rv_wait = 1'b0;
      rv.rv_dout = (cyc == rd_due) ? rd_data : 16'($urandom);
    end
  end

  bit          prev_req = 1'b0;
  bit          prev_ready = 1'b0;
  logic [41:0] prev_bus;

  always @(negedge clk) begin
    if (!resetn) begin
      prev_req   = 1'b0;
      prev_ready = 1'b0;
    end else begin
      check("err_timeout", 64'(err_timeout), 64'(exp_err));
      check("rd_wr_exclusive", 64'(rv.rv_rd & rv.rv_wr), 64'd0);
      if (prev_req)
        check("req_hold", 64'({rv.rv_rd, rv.rv_wr, rv.rv_addr, rv.rv_ds, rv.rv_din}), 64'(prev_bus));
      if ((rv.rv_rd | rv.rv_wr) && rv.rv_wait) begin
        half_waits++;
        if (half_waits >= WMAX) exp_err = 1'b1;
        if (wait_pending > 0) wait_pending--;
      end
      if ((rv.rv_rd | rv.rv_wr) && !rv.rv_wait) begin
        half_waits = 0;
        if (rv_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access: got addr 0x%0h rd=%0d wr=%0d expected none", rv.rv_addr, rv.rv_rd, rv.rv_wr);
        end else begin
          rv_exp_t e;
          e = rv_q.pop_front();
          check("rv_kind", 64'({rv.rv_rd, rv.rv_wr}), 64'({e.is_rd, !e.is_rd}));
          check("rv_addr", 64'(rv.rv_addr), 64'(e.addr));
          check("rv_ds", 64'(rv.rv_ds), 64'(e.ds));
          if (!e.is_rd) check("rv_din", 64'(rv.rv_din), 64'(e.din));
        end
        if (rv.rv_rd) begin
          rd_due  = cyc + L;
          rd_data = sd_mem[rv.rv_addr[10:0]];
        end else begin
          if (rv.rv_ds[0]) sd_mem[rv.rv_addr[10:0]][7:0]  = rv.rv_din[7:0];
          if (rv.rv_ds[1]) sd_mem[rv.rv_addr[10:0]][15:8] = rv.rv_din[15:8];
        end
      end
      prev_req = (rv.rv_rd | rv.rv_wr) && rv.rv_wait;
      prev_bus = {rv.rv_rd, rv.rv_wr, rv.rv_addr, rv.rv_ds, rv.rv_din};

      if (mem.mem_ready) begin
        check("ready_single_pulse", 64'(prev_ready), 64'd0);
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got mem_ready=1 expected no pending transaction");
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          check(r.is_rd ? "mem_rdata" : "mem_rdata_hold", 64'(mem.mem_rdata), 64'(r.data));
          if (r.lat >= 0) check("latency", 64'(cyc - r.issue + 1), 64'(r.lat));
          $display("txn %s done: rdata=0x%08h cycles=%0d", r.is_rd ? "read " : "write", mem.mem_rdata, cyc - r.issue + 1);
        end
      end
      prev_ready = mem.mem_ready;
    end
  end

  // Called at posedge+1; returns at posedge+1 after mem_ready has been seen.
  task automatic do_txn(input logic [22:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                        input int exp_lat, input bit drop);
    int      w;
    int      n;
    bit      done;
    rv_exp_t e;
    rsp_t    r;
    w = int'(addr[11:2]);
    r.is_rd = (wstrb == 4'b0000);
    if (r.is_rd) begin
      e.is_rd = 1'b1; e.din = 16'h0; e.ds = 2'b11;
      e.addr = {addr[22:2], 1'b0}; rv_q.push_back(e);
      e.addr = {addr[22:2], 1'b1}; rv_q.push_back(e);
      r.data = ref_mem[w];
      last_rdata = ref_mem[w];
    end else begin
      e.is_rd = 1'b0;
      if (wstrb[1:0] != 2'b00) begin
        e.addr = {addr[22:2], 1'b0}; e.din = wdata[15:0]; e.ds = wstrb[1:0]; rv_q.push_back(e);
      end
      if (wstrb[3:2] != 2'b00) begin
        e.addr = {addr[22:2], 1'b1}; e.din = wdata[31:16]; e.ds = wstrb[3:2]; rv_q.push_back(e);
      end
      r.data = last_rdata;
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
    end
    r.lat = exp_lat;
    r.issue = cyc;
    rsp_q.push_back(r);
    mem.mem_valid = 1'b1;
    mem.mem_addr  = addr;
    mem.mem_wdata = wdata;
    mem.mem_wstrb = wstrb;
    if (drop) begin
      @(posedge clk);
      #1;
      mem.mem_valid = 1'b0;
      mem.mem_addr  = 23'($urandom);
      mem.mem_wdata = $urandom;
      mem.mem_wstrb = 4'($urandom);
    end
    done = 1'b0;
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
      if (mem.mem_ready) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout: got no mem_ready within 2000 cycles expected completion addr 0x%0h", addr);
    end
    @(posedge clk);
    #1;
    mem.mem_valid = 1'b0;
  endtask

  task automatic flush_model();
    rv_q.delete();
    rsp_q.delete();
    exp_err      = 1'b0;
    half_waits   = 0;
    wait_pending = 0;
    last_rdata   = 32'h0;
    rd_due       = -1;
  endtask

  initial begin
    int          lat;
    int          n;
    logic [3:0]  s;
    bit          wr;
    bit          dr;
    rv_exp_t     e;

    for (int h = 0; h < 2048; h++) sd_mem[h] = seed_half(h);
    for (int w = 0; w < 1024; w++) ref_mem[w] = {seed_half(2*w + 1), seed_half(2*w)};
    sd_mem[11'h082] = 16'h1111;
    sd_mem[11'h083] = 16'h2222;
    ref_mem[10'h041] = 32'h2222_1111;
    mem.mem_valid = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    mem.mem_wstrb = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_mem_ready", 64'(mem.mem_ready), 64'd0);
    check("reset_mem_rdata", 64'(mem.mem_rdata), 64'd0);
    check("reset_rv_bus", 64'({rv.rv_rd, rv.rv_wr, rv.rv_addr, rv.rv_din, rv.rv_ds}), 64'd0);
    check("reset_err", 64'(err_timeout), 64'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    do_txn(23'h000104, 32'h0, 4'b0000, 4 + 2*L, 1'b0);
    do_txn(23'h000104, 32'hA1B2_C3D4, 4'b1111, 4, 1'b0);
    do_txn(23'h000104, 32'h0, 4'b0000, 4 + 2*L, 1'b0);
    do_txn(23'h000104, 32'h5566_7788, 4'b1100, 3, 1'b0);
    do_txn(23'h000104, 32'h0000_9900, 4'b0010, 3, 1'b0);
    do_txn(23'h000106, 32'h0, 4'b0000, 4 + 2*L, 1'b0);

    wait_pending = 3;
    do_txn(23'h000200, 32'h0, 4'b0000, -1, 1'b0);
    check("err_after_3_waits", 64'(err_timeout), 64'd0);
    wait_pending = WMAX - 1;
    do_txn(23'h000300, 32'hCAFE_F00D, 4'b1111, -1, 1'b0);
    check("err_after_254_waits", 64'(err_timeout), 64'd0);
    wait_pending = 300;
    do_txn(23'h000304, 32'h1234_5678, 4'b0011, -1, 1'b0);
    check("err_after_300_waits", 64'(err_timeout), 64'd1);

    do_txn(23'h000300, 32'h0, 4'b0000, 4 + 2*L, 1'b1);

    for (int t = 0; t < 40; t++) begin
      s  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      wr = 1'($urandom_range(0, 1));
      dr = ($urandom_range(0, 3) == 0);
      wait_rand = wr;
      if (wr)                                     lat = -1;
      else if (s == 4'h0)                         lat = 4 + 2*L;
      else if (s[1:0] != 2'b00 && s[3:2] != 2'b00) lat = 4;
      else                                        lat = 3;
      do_txn(23'($urandom), $urandom, s, lat, dr);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    wait_rand = 1'b0;
    @(posedge clk);
    #1;

    // Reset while a read is stalled in its low-half request.
    wait_pending = 1000;
    mem.mem_valid = 1'b1;
    mem.mem_addr  = 23'h000400;
    mem.mem_wstrb = 4'b0000;
    repeat (5) @(posedge clk);
    #1;
    check("stalled_rv_rd", 64'(rv.rv_rd), 64'd1);
    #1;
    resetn = 1'b0;
    #1;
    check("async_reset_req", 64'({rv.rv_rd, rv.rv_wr, mem.mem_ready}), 64'd0);
    check("async_reset_err", 64'(err_timeout), 64'd0);
    mem.mem_valid = 1'b0;
    flush_model();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Reset while waiting for low-half read data.
    e.is_rd = 1'b1; e.addr = {21'h000100, 1'b0}; e.din = 16'h0; e.ds = 2'b11;
    rv_q.push_back(e);
    mem.mem_valid = 1'b1;
    mem.mem_addr  = 23'h000400;
    mem.mem_wstrb = 4'b0000;
    n = 0;
    while (rv_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("lo_half_accepted", 64'(rv_q.size()), 64'd0);
    resetn = 1'b0;
    #1;
    check("rd_lo_reset_outputs", 64'({rv.rv_rd, rv.rv_wr, mem.mem_ready}), 64'd0);
    check("rd_lo_reset_rdata", 64'(mem.mem_rdata), 64'd0);
    mem.mem_valid = 1'b0;
    flush_model();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    do_txn(23'h000400, 32'h0BAD_BEEF, 4'b1111, 4, 1'b0);
    do_txn(23'h000400, 32'h0, 4'b0000, 4 + 2*L, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("rv_queue_drained", 64'(rv_q.size()), 64'd0);
    check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    checks++;
    $display("FAIL watchdog: got no end of test expected finish before 2ms");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
